// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter sharing the register bank write port among NREQ writeback sources.
// Define REG_WR_LOCK_EN to enable the LOCKED state (one requester owns the port for a burst).
module reg_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic [NREQ-1:0]      req_lock,
  output logic [NREQ-1:0]      req_ready,
  output logic                 wrReg,
  output logic [AW-1:0]        rd,
  output logic [DW-1:0]        rdIn,
  output logic [(1<<AW)-1:0]   pend_mask,
  output logic                 locked
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NR = 1 << AW;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [DW-1:0]   rdin_q, rdin_d;
  logic [NR-1:0]   pend_q, pend_d;

  logic            found_s;
  logic [PW-1:0]   gidx_s;
  logic            hs_s;
  logic [AW-1:0]   sel_rd_s;
  logic [DW-1:0]   sel_data_s;
  logic [PW:0]     pick_s;

  // Returns {found, index} of the first valid requester at or after p, wrapping.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] v, input logic [PW-1:0] p);
    logic [PW:0] res;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (v[(int'(p) + k) % NREQ]) begin
        res = {1'b1, PW'((int'(p) + k) % NREQ)};
      end
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] i);
    return (i == PW'(NREQ - 1)) ? '0 : i + PW'(1);
  endfunction

  always_comb begin
    pick_s  = rr_pick(req_valid, ptr_q);
    found_s = 1'b0;
    gidx_s  = '0;
    if (state_q == LOCKED) begin
      found_s = req_valid[owner_q];
      gidx_s  = owner_q;
    end else begin
      found_s = pick_s[PW];
      gidx_s  = pick_s[PW-1:0];
    end
    // No grant is offered while reset is held low.
    hs_s      = found_s & reset;
    req_ready = '0;
    if (hs_s) begin
      req_ready[gidx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
    sel_rd_s   = req_rd[int'(gidx_s)*AW +: AW];
    sel_data_s = req_data[int'(gidx_s)*DW +: DW];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (hs_s) begin
`ifdef REG_WR_LOCK_EN
      if (state_q == LOCKED) begin
        if (!req_lock[gidx_s]) begin
          state_d = ARB;
          ptr_d   = ptr_next(gidx_s);
        end else begin
          state_d = LOCKED;
        end
      end else if (req_lock[gidx_s]) begin
        state_d = LOCKED;
        owner_d = gidx_s;
      end else begin
        ptr_d = ptr_next(gidx_s);
      end
`else
      ptr_d = ptr_next(gidx_s);
`endif
    end else begin
      state_d = state_q;
    end

    // R0 writes are accepted but never reach the bank.
    wr_d   = hs_s && (sel_rd_s != '0);
    rd_d   = hs_s ? sel_rd_s : rd_q;
    rdin_d = hs_s ? sel_data_s : rdin_q;
    pend_d = '0;
    if (wr_d) begin
      pend_d[rd_d] = 1'b1;
    end else begin
      pend_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
      rdin_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      rdin_q  <= rdin_d;
      pend_q  <= pend_d;
    end
  end

  assign wrReg     = wr_q;
  assign rd        = rd_q;
  assign rdIn      = rdin_q;
  assign pend_mask = pend_q;

`ifdef REG_WR_LOCK_EN
  assign locked = (state_q == LOCKED);
`else
  logic unused_lock_s;
  assign unused_lock_s = ^req_lock;
  assign locked        = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Scoreboard bench for reg_wr_arbiter: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares. Expectations follow REG_WR_LOCK_EN if defined.
module tb_reg_wr_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 4;
`ifdef REG_WR_LOCK_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif

  localparam logic [31:0] DA = 32'hAAAA_0001;
  localparam logic [31:0] DB = 32'hBBBB_0002;
  localparam logic [31:0] DC = 32'hCCCC_0003;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_rd;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ-1:0]   req_ready;
  logic              wrReg;
  logic [AW-1:0]     rd;
  logic [DW-1:0]     rdIn;
  logic [15:0]       pend_mask;
  logic              locked;

  typedef struct {
    int          step;
    logic [2:0]  rdy;
    logic        wr;
    logic [3:0]  rd;
    logic [31:0] dat;
    logic        lkd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  reg_wr_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rd(req_rd),
    .req_data(req_data), .req_lock(req_lock), .req_ready(req_ready),
    .wrReg(wrReg), .rd(rd), .rdIn(rdIn), .pend_mask(pend_mask), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int st, input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL step %0d %s: got %h want %h", st, nm, act, want);
    end
  endtask

  // Monitor: compare DUT outputs against the expected record for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [15:0] ep;
      e  = exp_q.pop_front();
      ep = e.wr ? (16'h0001 << e.rd) : 16'h0000;
      chk(e.step, "req_ready", {29'd0, req_ready}, {29'd0, e.rdy});
      chk(e.step, "wrReg", {31'd0, wrReg}, {31'd0, e.wr});
      chk(e.step, "rd", {28'd0, rd}, {28'd0, e.rd});
      chk(e.step, "rdIn", rdIn, e.dat);
      chk(e.step, "pend_mask", {16'd0, pend_mask}, {16'd0, ep});
      chk(e.step, "locked", {31'd0, locked}, {31'd0, e.lkd});
    end
  end

  // One cycle of stimulus plus the hand-computed outputs expected in that cycle.
  task automatic cyc(input logic rst, input logic [2:0] v, input logic [11:0] rdp,
                     input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                     input logic [2:0] lk, input logic [2:0] er, input logic ew,
                     input logic [3:0] erd, input logic [31:0] edat, input logic elk);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    req_valid = v;
    req_rd    = rdp;
    req_data  = {d2, d1, d0};
    req_lock  = lk;
    step++;
    e.step = step; e.rdy = er; e.wr = ew; e.rd = erd; e.dat = edat; e.lkd = elk;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; req_valid = '0; req_rd = '0; req_data = '0; req_lock = '0;

    // Reset held with everyone valid
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 3'b111, {4'd3, 4'd2, 4'd1}, DA, DB, DC, 3'b000, 3'b000, 1'b0, 4'd0, 32'd0, 1'b0);

    // Fairness: grants 0,1,2,0,1,2
    cyc(1'b1, 3'b111, {4'd3, 4'd2, 4'd1}, DA, DB, DC, 3'b000, 3'b001, 1'b0, 4'd0, 32'd0, 1'b0);
    cyc(1'b1, 3'b111, {4'd3, 4'd2, 4'd1}, DA, DB, DC, 3'b000, 3'b010, 1'b1, 4'd1, DA, 1'b0);
    cyc(1'b1, 3'b111, {4'd3, 4'd2, 4'd1}, DA, DB, DC, 3'b000, 3'b100, 1'b1, 4'd2, DB, 1'b0);
    cyc(1'b1, 3'b111, {4'd3, 4'd2, 4'd1}, DA, DB, DC, 3'b000, 3'b001, 1'b1, 4'd3, DC, 1'b0);
    cyc(1'b1, 3'b111, {4'd3, 4'd2, 4'd1}, DA, DB, DC, 3'b000, 3'b010, 1'b1, 4'd1, DA, 1'b0);
    cyc(1'b1, 3'b111, {4'd3, 4'd2, 4'd1}, DA, DB, DC, 3'b000, 3'b100, 1'b1, 4'd2, DB, 1'b0);
    cyc(1'b1, 3'b000, {4'd3, 4'd2, 4'd1}, DA, DB, DC, 3'b000, 3'b000, 1'b1, 4'd3, DC, 1'b0);

    // R0 write: accepted, no wrReg, pointer moves to 2
    cyc(1'b1, 3'b010, {4'd3, 4'd0, 4'd1}, DA, 32'hDEAD, DC, 3'b000, 3'b010, 1'b0, 4'd3, DC, 1'b0);
    cyc(1'b1, 3'b111, {4'd3, 4'd2, 4'd1}, DA, DB, DC, 3'b000, 3'b100, 1'b0, 4'd0, 32'hDEAD, 1'b0);
    cyc(1'b1, 3'b000, {4'd3, 4'd2, 4'd1}, DA, DB, DC, 3'b000, 3'b000, 1'b1, 4'd3, DC, 1'b0);

    // Lock burst from requester 1 (pointer first moved to 1)
    cyc(1'b1, 3'b001, {4'd9, 4'd4, 4'd7}, 32'h77, 32'h44, 32'h99, 3'b000, 3'b001, 1'b0, 4'd3, DC, 1'b0);
    cyc(1'b1, 3'b111, {4'd9, 4'd4, 4'd8}, 32'h88, 32'h44, 32'h99, 3'b010, 3'b010, 1'b1, 4'd7, 32'h77, 1'b0);
    cyc(1'b1, 3'b111, {4'd9, 4'd5, 4'd8}, 32'h88, 32'h55, 32'h99, 3'b010,
        LK ? 3'b010 : 3'b100, 1'b1, 4'd4, 32'h44, LK);
    cyc(1'b1, 3'b111, {4'd9, 4'd6, 4'd8}, 32'h88, 32'h66, 32'h99, 3'b000,
        LK ? 3'b010 : 3'b001, 1'b1, LK ? 4'd5 : 4'd9, LK ? 32'h55 : 32'h99, LK);
    cyc(1'b1, 3'b101, {4'd9, 4'd6, 4'd8}, 32'h88, 32'h66, 32'h99, 3'b000,
        3'b100, 1'b1, LK ? 4'd6 : 4'd8, LK ? 32'h66 : 32'h88, 1'b0);
    cyc(1'b1, 3'b000, {4'd9, 4'd6, 4'd8}, 32'h88, 32'h66, 32'h99, 3'b000, 3'b000, 1'b1, 4'd9, 32'h99, 1'b0);

    // Reset in the middle of a lock
    cyc(1'b1, 3'b001, {4'd3, 4'd10, 4'd1}, 32'h11, 32'hAA, 32'h33, 3'b000, 3'b001, 1'b0, 4'd9, 32'h99, 1'b0);
    cyc(1'b1, 3'b111, {4'd3, 4'd10, 4'd2}, 32'h22, 32'hAA, 32'h33, 3'b010, 3'b010, 1'b1, 4'd1, 32'h11, 1'b0);
    cyc(1'b0, 3'b111, {4'd3, 4'd10, 4'd2}, 32'h22, 32'hAA, 32'h33, 3'b010, 3'b000, 1'b1, 4'd10, 32'hAA, LK);
    cyc(1'b1, 3'b111, {4'd3, 4'd10, 4'd2}, 32'h22, 32'hAA, 32'h33, 3'b000, 3'b001, 1'b0, 4'd0, 32'd0, 1'b0);
    cyc(1'b1, 3'b000, {4'd3, 4'd10, 4'd2}, 32'h22, 32'hAA, 32'h33, 3'b000, 3'b000, 1'b1, 4'd2, 32'h22, 1'b0);

    // Idle owner: lock to requester 2, owner drops valid for 4 cycles
    cyc(1'b1, 3'b100, {4'd12, 4'd0, 4'd13}, 32'hDD, 32'h0, 32'hCC, 3'b100, 3'b100, 1'b0, 4'd2, 32'h22, 1'b0);
    cyc(1'b1, 3'b001, {4'd12, 4'd0, 4'd13}, 32'hDD, 32'h0, 32'hCC, 3'b000,
        LK ? 3'b000 : 3'b001, 1'b1, 4'd12, 32'hCC, LK);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 3'b001, {4'd12, 4'd0, 4'd13}, 32'hDD, 32'h0, 32'hCC, 3'b000,
          LK ? 3'b000 : 3'b001, !LK, LK ? 4'd12 : 4'd13, LK ? 32'hCC : 32'hDD, LK);
    cyc(1'b1, 3'b101, {4'd14, 4'd0, 4'd13}, 32'hDD, 32'h0, 32'hCC, 3'b000,
        3'b100, !LK, LK ? 4'd12 : 4'd13, LK ? 32'hCC : 32'hDD, LK);
    cyc(1'b1, 3'b000, {4'd14, 4'd0, 4'd13}, 32'hDD, 32'h0, 32'hCC, 3'b000, 3'b000, 1'b1, 4'd14, 32'hCC, 1'b0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_wr_arbiter.md
# reg_wr_arbiter

Shares the register bank's single write port (wrReg/rd/rdIn) among NREQ writeback sources (ALU, load unit, debug/loader) using round-robin arbitration with a valid/ready handshake. Winning writes are registered and presented to the register bank one cycle after acceptance, with a one-hot pending-write mask for hazard/stall logic. An optional lock mode lets one requester own the port for a multi-write burst.

## Interface
- NREQ, 3, number of requesters (2..8)
- DW, 32, data width
- AW, 4, register address width (16 registers)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  NREQ  requester i has a write pending
- req_rd  in  NREQ*AW  destination register, requester i at bits [i*AW +: AW]
- req_data  in  NREQ*DW  write data, requester i at bits [i*DW +: DW]
- req_lock  in  NREQ  requester i requests port ownership after this write (macro-dependent)
- req_ready  out  NREQ  one-hot grant; handshake when req_valid[i] && req_ready[i]
- wrReg  out  1  write enable to register bank
- rd  out  AW  write address to register bank
- rdIn  out  DW  write data to register bank
- pend_mask  out  2**AW  one-hot of register being written this cycle (zero if none)
- locked  out  1  port currently owned by a requester

## Operation
- States: ARB (round-robin among all), LOCKED (only lock_owner eligible).
- ARB: grant lowest index i >= ptr with req_valid[i], wrapping modulo NREQ; req_ready is combinational, at most one bit set, zero when no valid.
- After a handshake by requester i: ptr <= (i+1) mod NREQ. No handshake: ptr unchanged.
- Handshake with req_lock[i]=1 in ARB: lock_owner <= i, state -> LOCKED, ptr unchanged.
- LOCKED: req_ready[owner] = req_valid[owner]; all other ready bits 0, even if owner idle. Handshake by owner with req_lock=0: state -> ARB, ptr <= (owner+1) mod NREQ.
- Output register: on handshake, rd <= req_rd[i], rdIn <= req_data[i], wrReg <= (req_rd[i] != 0); otherwise wrReg <= 0, rd/rdIn hold.
- Writes to R0 are accepted (ready asserted, ptr advances) but produce wrReg=0 and pend_mask=0.
- pend_mask = wrReg ? (1 << rd) : 0.
- Requesters hold req_valid, req_rd, req_data stable until handshake; the arbiter never retracts an offered grant to a still-valid requester within the same cycle.

## Timing
- Acceptance to wrReg: 1 cycle; register bank commits on the following edge (2 edges total).
- Throughput: one write per cycle, back-to-back across or within requesters.
- Reset (reset=0 at clk edge): wrReg=0, rd=0, rdIn=0, pend_mask=0, locked=0, ptr=0, state ARB; req_ready=0 during reset cycles. Reset mid-burst drops the lock and any not-yet-registered write; a write already on wrReg at the reset edge is squashed.
- Simultaneous valid from all requesters with ptr=k: grant k, then k+1, ... fair within NREQ cycles.
- req_valid deasserting without handshake: no state change.

## Configuration
- REG_WR_LOCK_EN defined: LOCKED state and req_lock behaviour as above; locked output reflects state.
- Undefined: req_lock ignored, state machine is ARB only, locked tied 0; all other behaviour identical.

## Test plan
- Reset: hold reset=0 3 cycles with all req_valid=1 -> req_ready=0, wrReg=0, pend_mask=0, rd=0, rdIn=0.
- Fairness: NREQ=3, all valid continuously (rd=1,2,3; data A,B,C) from ptr=0 -> grants 0,1,2,0...; wrReg=1 each cycle, rd=1,2,3 one cycle after each grant, pend_mask=0x0002,0x0004,0x0008.
- R0 drop: requester 1 alone writes rd=0 data 0xDEAD -> req_ready[1]=1, next cycle wrReg=0, pend_mask=0; next grant from ptr=2.
- Lock burst (REG_WR_LOCK_EN): req1 writes rd=4,5,6 with lock=1,1,0 while req0/req2 valid -> locked=1 after first write, three consecutive req1 writes, then req2 granted; without macro, grants alternate 1,2,0.
- Reset mid-lock: assert reset during req1 burst -> locked=0, wrReg=0 next cycle, ptr=0, req0 granted first after release.
- Idle owner: locked to req2, req2 drops valid 4 cycles while req0 valid -> req_ready all zero, wrReg=0 for those cycles.
